// File: rtl/beta_if_stage_pkg.sv
// rtl/beta_if_stage_pkg.sv - shared IF-stage types: imem responder FSM encoding and counter sizing
package beta_if_stage_pkg;

    localparam int unsigned imem_rsp_fsm_bsize = 2;

    typedef enum logic [imem_rsp_fsm_bsize-1:0] {
        IMEM_RSP_IDLE  = 2'd0,
        IMEM_RSP_GRANT = 2'd1,
        IMEM_RSP_WAIT  = 2'd2,
        IMEM_RSP_RESP  = 2'd3
    } imem_rsp_state_e;

    // Latency counter must hold ReadLatency-1; never narrower than one bit.
    function automatic int unsigned imem_rsp_cnt_width(input int unsigned read_latency);
        return (read_latency < 2) ? 1 : $clog2(read_latency + 1);
    endfunction

endpackage

// File: rtl/beta_imem_array.sv
// rtl/beta_imem_array.sv - single-clock instruction RAM, sync write, registered sync read
module beta_imem_array #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MemDepth  = 1024,
    parameter int unsigned IdxW      = $clog2(MemDepth)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 we_i,
    input  logic [IdxW-1:0]      waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 re_i,
    input  logic                 rclr_i,
    input  logic [IdxW-1:0]      raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem_q [MemDepth];
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the read register is reset; a same-index write lands after this read samples.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rdata_q <= '0;
        end else if (rclr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/beta_imem_responder.sv
// rtl/beta_imem_responder.sv - imem request/ready/valid responder with preload port
module beta_imem_responder
    import beta_if_stage_pkg::*;
#(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned MemDepth    = 1024,
    parameter int unsigned ReadLatency = 1
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 imem_req_i,
    input  logic [AddrWidth-1:0] imem_addr_i,
    output logic                 imem_ready_o,
    output logic                 imem_valid_o,
    output logic [DataWidth-1:0] imem_rdata_o,
    output logic                 imem_err_o,
    output logic                 imem_busy_o,
    input  logic                 load_we_i,
    input  logic [AddrWidth-1:0] load_addr_i,
    input  logic [DataWidth-1:0] load_data_i
);

    localparam int unsigned OffW = $clog2(DataWidth / 8);
    localparam int unsigned IdxW = $clog2(MemDepth);
    localparam int unsigned CntW = imem_rsp_cnt_width(ReadLatency);
    localparam logic [CntW-1:0] CntLoad = CntW'(ReadLatency - 1);

    function automatic logic addr_bad(input logic [AddrWidth-1:0] a);
        return (a[OffW-1:0] != '0) || (a[AddrWidth-1:OffW+IdxW] != '0);
    endfunction

    imem_rsp_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q;
    logic            bad_q;
    logic            ready_q, valid_q, err_q, busy_q;
    logic            entering_resp;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IMEM_RSP_IDLE: begin
                if (imem_req_i) begin
                    state_d = IMEM_RSP_GRANT;
                end
            end
            IMEM_RSP_GRANT: begin
                cnt_d   = CntLoad;
                state_d = (ReadLatency > 1) ? IMEM_RSP_WAIT : IMEM_RSP_RESP;
            end
            IMEM_RSP_WAIT: begin
                cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
                if (cnt_q <= CntW'(1)) begin
                    state_d = IMEM_RSP_RESP;
                end
            end
            IMEM_RSP_RESP: begin
                state_d = IMEM_RSP_IDLE;
            end
            default: state_d = IMEM_RSP_IDLE;
        endcase
    end

    assign entering_resp = (state_d == IMEM_RSP_RESP);

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IMEM_RSP_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            bad_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IMEM_RSP_IDLE && imem_req_i) begin
                idx_q <= imem_addr_i[OffW +: IdxW];
                bad_q <= addr_bad(imem_addr_i);
            end
            ready_q <= (state_d == IMEM_RSP_GRANT);
            valid_q <= entering_resp;
            err_q   <= entering_resp && bad_q;
            busy_q  <= (state_d != IMEM_RSP_IDLE);
        end
    end

    beta_imem_array #(
        .DataWidth(DataWidth),
        .MemDepth (MemDepth),
        .IdxW     (IdxW)
    ) u_array (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .we_i   (load_we_i && !addr_bad(load_addr_i)),
        .waddr_i(load_addr_i[OffW +: IdxW]),
        .wdata_i(load_data_i),
        .re_i   (entering_resp && !bad_q),
        .rclr_i (entering_resp && bad_q),
        .raddr_i(idx_q),
        .rdata_o(imem_rdata_o)
    );

    assign imem_ready_o = ready_q;
    assign imem_valid_o = valid_q;
    assign imem_err_o   = err_q;
    assign imem_busy_o  = busy_q;

endmodule

// File: doc/beta_imem_responder.md
# beta_imem_responder

Instruction-memory responder for the IF-stage imem request/ready/valid protocol: it accepts one fetch request at a time, grants it with a one-cycle ready pulse, waits a configurable read latency, then returns the addressed word with a one-cycle valid pulse. It sits opposite `beta_fetch_unit` and serves as the on-chip instruction TCM and simulation memory model for the core. A side-band load port lets the bench or a boot loader preload program words.

## Interface
- `DataWidth`, 32, width of instruction words (32 or 64)
- `AddrWidth`, 32, width of the byte address
- `MemDepth`, 1024, number of words in the array (power of two)
- `ReadLatency`, 1, cycles from the ready pulse to the valid pulse (≥1)
- `clk_i`  in  1  clock; all logic on the rising edge
- `rstn_i`  in  1  reset; asynchronous, active-low
- `imem_req_i`  in  1  fetch request from the initiator
- `imem_addr_i`  in  AddrWidth  byte address, sampled with the request
- `imem_ready_o`  out  1  request accepted; one-cycle pulse
- `imem_valid_o`  out  1  `imem_rdata_o` valid; one-cycle pulse
- `imem_rdata_o`  out  DataWidth  returned instruction word
- `imem_err_o`  out  1  pulses with `imem_valid_o` when the address was misaligned or out of range
- `imem_busy_o`  out  1  a request is in flight (GRANT, WAIT or RESP)
- `load_we_i`  in  1  preload write enable
- `load_addr_i`  in  AddrWidth  preload byte address
- `load_data_i`  in  DataWidth  preload word

## Operation
- Word index = `addr[AddrWidth-1 : log2(DataWidth/8)]`. Misaligned if the low bits are not zero. Out of range if index ≥ `MemDepth`.
- FSM states:
  - **RSP_IDLE**: when `imem_req_i`=1, latch the address, go to RSP_GRANT.
  - **RSP_GRANT**: `imem_ready_o`=1. Load the latency counter with `ReadLatency-1`. Go to RSP_WAIT if `ReadLatency`>1, else RSP_RESP.
  - **RSP_WAIT**: decrement the counter; go to RSP_RESP when it reaches 0.
  - **RSP_RESP**: `imem_valid_o`=1 with data (and `imem_err_o` if applicable), then go to RSP_IDLE.
- `imem_req_i` is ignored outside RSP_IDLE. The initiator drops the request after seeing ready.
- Read data is the array word at the latched index, read in the cycle that enters RSP_RESP. On error, `imem_rdata_o`='0.
- `imem_rdata_o` holds its last value between responses.
- Load port writes in any state. Writes to out-of-range or misaligned addresses are dropped.
- A load write to the same index in the same cycle as the array read returns the old data (read-before-write).
- Only one request is outstanding; there is no queueing.

## Timing
- Reset values: all outputs 0, state RSP_IDLE, counter 0. Array contents are not reset.
- Reset mid-transaction aborts immediately to RSP_IDLE. No ready or valid pulse follows.
- With req sampled high at edge N:
  - ready is high in cycle N+1.
  - valid is high in cycle N+1+`ReadLatency`.
- All outputs are registered.
- A request may be sampled in the cycle after valid (RSP_IDLE). Back-to-back request-to-request spacing is `ReadLatency`+2 cycles.
- `imem_busy_o` is high from cycle N+1 through the valid cycle inclusive.
- A request asserted during RSP_RESP is not sampled until RSP_IDLE. It is served one cycle later, never lost, provided req is held.

## Structure
- Add to `beta_if_stage_pkg`:
  - responder state encoding (`IMEM_RSP_IDLE/GRANT/WAIT/RESP`) and its `imem_rsp_fsm_bsize`
  - latency counter width `$clog2(ReadLatency+1)`
- Sub-module `beta_imem_array`: single-clock RAM with sync write port and sync read (`MemDepth` × `DataWidth`), no reset.
- Top holds the FSM, address decode and error check, counter, and output registers.

## Test plan
- Preload 0x00000013 at 0x0, req addr 0x0, `ReadLatency`=1 → ready in cycle 1, valid with rdata 0x00000013 in cycle 2, err=0.
- `ReadLatency`=4, req addr 0x8 preloaded 0xDEADBEEF → ready in cycle 1, valid plus data in cycle 5, busy high in cycles 1–5.
- Req addr 0x2 (misaligned), then addr 0x1000 with `MemDepth`=1024 (out of range) → each returns valid with err=1 and rdata=0.
- Connect to `beta_fetch_unit` with fetch_en held high, preload words 0..7 with 0x100+i:
  - eight consecutive fetches return matching words with `new_instr_o` each time
  - fetches are spaced `ReadLatency`+2 cycles apart
- Assert `rstn_i` low in RSP_WAIT (`ReadLatency`=4) → outputs 0 immediately, no valid pulse follows, next request is served normally.
- Load write 0xCAFEF00D at the index being read in the RSP_RESP entry cycle → old data returned; the following read returns 0xCAFEF00D.
